// File: rtl/motor_emf_multi.sv
// motor_emf_multi: multi-channel back-EMF estimator, emf = GAIN*(cmd-fb) - RES[ch]*fb in Q8.8,
// one shared multiplier stepped over all channels. Optional define MOTOR_EMF_FILTER_EN adds a low-pass.
module motor_emf_multi #(
  parameter int          NUM_CH     = 4,
  parameter int          EMF_W      = 17,
  parameter int unsigned GAIN       = 12224,
  parameter int unsigned RES_RST    = 2030,
  parameter int          FILT_SHIFT = 3,
  localparam int         CH_AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    val_ready,
  input  logic [16*NUM_CH-1:0]    cur_cmd,
  input  logic [16*NUM_CH-1:0]    cur_fb,
  input  logic                    cfg_wr,
  input  logic [CH_AW-1:0]        cfg_addr,
  input  logic [15:0]             cfg_data,
  output logic                    busy,
  output logic                    emf_ready,
  output logic [EMF_W*NUM_CH-1:0] emf_out,
  output logic [NUM_CH-1:0]       emf_ovf,
  output logic                    trig_miss
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAPT  = 3'd1,
    ST_MUL_G = 3'd2,
    ST_MUL_R = 3'd3,
    ST_SUB   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [15:0]             GAIN_Q  = 16'(GAIN);
  localparam logic [15:0]             RES_Q   = 16'(RES_RST);
  localparam logic [CH_AW-1:0]        LAST_CH = CH_AW'(NUM_CH - 1);
  localparam logic signed [EMF_W-1:0] EMF_MAX = {1'b0, {(EMF_W-1){1'b1}}};
  localparam logic signed [EMF_W-1:0] EMF_MIN = {1'b1, {(EMF_W-1){1'b0}}};
  localparam logic signed [34:0]      SAT_MAX = 35'(EMF_MAX);
  localparam logic signed [34:0]      SAT_MIN = 35'(EMF_MIN);

  if ((NUM_CH < 1) || (NUM_CH > 8) || (EMF_W < 17) || (EMF_W > 24) || (FILT_SHIFT < 1)
      || (FILT_SHIFT > 15)) begin : g_bad_cfg
    $error("motor_emf_multi: parameter out of range");
  end

  state_t                  state_r;
  logic [CH_AW-1:0]        ch_r;
  logic                    val_ready_d_r;
  logic                    trigger_s;
  logic [15:0]             res_r    [NUM_CH];
  logic [15:0]             res_sh_r [NUM_CH];
  logic [15:0]             cmd_r    [NUM_CH];
  logic [15:0]             fb_r     [NUM_CH];
  logic signed [EMF_W-1:0] hold_r   [NUM_CH];
  logic [NUM_CH-1:0]       ovf_hold_r;
  logic signed [33:0]      drive_r;
  logic signed [33:0]      vres_r;
  logic signed [15:0]      cmd_s;
  logic signed [15:0]      fb_s;
  logic signed [16:0]      mul_a_s;
  logic signed [16:0]      mul_b_s;
  logic signed [33:0]      mul_p_s;
  logic signed [34:0]      diff_s;
  logic signed [EMF_W-1:0] d_sat_s;
  logic signed [EMF_W-1:0] res_s;
  logic                    ovf_s;

  assign trigger_s = val_ready & ~val_ready_d_r;

  // Operand select for the single shared multiplier (gain term, then resistive term)
  always_comb begin
    cmd_s   = {~cmd_r[ch_r][15], cmd_r[ch_r][14:0]};
    fb_s    = {~fb_r[ch_r][15], fb_r[ch_r][14:0]};
    mul_a_s = 17'sd0;
    mul_b_s = 17'sd0;
    case (state_r)
      ST_MUL_G: begin
        mul_a_s = {cmd_s[15], cmd_s} - {fb_s[15], fb_s};
        mul_b_s = {1'b0, GAIN_Q};
      end
      ST_MUL_R: begin
        mul_a_s = {fb_s[15], fb_s};
        mul_b_s = {1'b0, res_sh_r[ch_r]};
      end
      default: begin
        mul_a_s = 17'sd0;
        mul_b_s = 17'sd0;
      end
    endcase
    mul_p_s = 34'(mul_a_s) * 34'(mul_b_s);
  end

  // Difference of the two scaled terms, clamped to the output range
  always_comb begin
    diff_s = {drive_r[33], drive_r} - {vres_r[33], vres_r};
    if (diff_s > SAT_MAX) begin
      d_sat_s = EMF_MAX;
      ovf_s   = 1'b1;
    end else if (diff_s < SAT_MIN) begin
      d_sat_s = EMF_MIN;
      ovf_s   = 1'b1;
    end else begin
      d_sat_s = diff_s[EMF_W-1:0];
      ovf_s   = 1'b0;
    end
  end

`ifdef MOTOR_EMF_FILTER_EN
  localparam logic signed [EMF_W:0] F_MAX = (EMF_W+1)'(EMF_MAX);
  localparam logic signed [EMF_W:0] F_MIN = (EMF_W+1)'(EMF_MIN);

  logic signed [EMF_W-1:0] y_r [NUM_CH];
  logic signed [EMF_W:0]   y_ext_s;
  logic signed [EMF_W:0]   f_diff_s;
  logic signed [EMF_W:0]   f_step_s;
  logic signed [EMF_W:0]   f_sum_s;

  // First-order low-pass step on the clamped result; kept fully signed so the shift stays arithmetic
  always_comb begin
    y_ext_s  = {y_r[ch_r][EMF_W-1], y_r[ch_r]};
    f_diff_s = {d_sat_s[EMF_W-1], d_sat_s} - y_ext_s;
    f_step_s = f_diff_s >>> FILT_SHIFT;
    f_sum_s  = y_ext_s + f_step_s;
    if (f_sum_s > F_MAX) begin
      res_s = EMF_MAX;
    end else if (f_sum_s < F_MIN) begin
      res_s = EMF_MIN;
    end else begin
      res_s = f_sum_s[EMF_W-1:0];
    end
  end

  // Filter state, advanced once per channel per conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        y_r[i] <= {EMF_W{1'b0}};
      end
    end else if (state_r == ST_SUB) begin
      y_r[ch_r] <= res_s;
    end
  end
`else
  // Unfiltered build publishes the clamped result directly
  always_comb begin
    res_s = d_sat_s;
  end
`endif

  // Runtime resistance table; out-of-range addresses are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        res_r[i] <= RES_Q;
      end
    end else if (cfg_wr && (32'(cfg_addr) < 32'(NUM_CH))) begin
      res_r[cfg_addr] <= cfg_data;
    end
  end

  // Conversion sequencer, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ch_r          <= {CH_AW{1'b0}};
      val_ready_d_r <= 1'b0;
      busy          <= 1'b0;
      emf_ready     <= 1'b0;
      trig_miss     <= 1'b0;
      emf_out       <= {(EMF_W*NUM_CH){1'b0}};
      emf_ovf       <= {NUM_CH{1'b0}};
      ovf_hold_r    <= {NUM_CH{1'b0}};
      drive_r       <= 34'sd0;
      vres_r        <= 34'sd0;
      for (int i = 0; i < NUM_CH; i++) begin
        res_sh_r[i] <= RES_Q;
        cmd_r[i]    <= 16'h8000;
        fb_r[i]     <= 16'h8000;
        hold_r[i]   <= {EMF_W{1'b0}};
      end
    end else begin
      val_ready_d_r <= val_ready;
      emf_ready     <= 1'b0;
      trig_miss     <= trigger_s & (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            state_r <= ST_CAPT;
            busy    <= 1'b1;
          end
        end
        ST_CAPT: begin
          for (int i = 0; i < NUM_CH; i++) begin
            cmd_r[i]    <= cur_cmd[16*i +: 16];
            fb_r[i]     <= cur_fb[16*i +: 16];
            res_sh_r[i] <= res_r[i];
          end
          ch_r    <= {CH_AW{1'b0}};
          state_r <= ST_MUL_G;
        end
        ST_MUL_G: begin
          drive_r <= mul_p_s >>> 4'd8;
          state_r <= ST_MUL_R;
        end
        ST_MUL_R: begin
          vres_r  <= mul_p_s >>> 4'd8;
          state_r <= ST_SUB;
        end
        ST_SUB: begin
          hold_r[ch_r]     <= res_s;
          ovf_hold_r[ch_r] <= ovf_s;
          if (ch_r == LAST_CH) begin
            // Last channel bypasses its holding register so all outputs land in the same cycle
            for (int i = 0; i < NUM_CH; i++) begin
              emf_out[i*EMF_W +: EMF_W] <= (CH_AW'(i) == ch_r) ? res_s : hold_r[i];
              emf_ovf[i]                <= (CH_AW'(i) == ch_r) ? ovf_s : ovf_hold_r[i];
            end
            emf_ready <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_DONE;
          end else begin
            ch_r    <= ch_r + CH_AW'(1'b1);
            state_r <= ST_MUL_G;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_emf_multi.sv
// Bench for motor_emf_multi: randomized conversions checked every cycle against an arithmetic
// reference model, plus hand-computed anchor values.
`timescale 1ns/1ps
module tb_motor_emf_multi;

  localparam int NUM_CH     = 4;
  localparam int EMF_W      = 17;
  localparam int GAIN       = 12224;
  localparam int RES_RST    = 2030;
  localparam int FILT_SHIFT = 3;
  localparam int LAT        = 2 + 3*NUM_CH;
  localparam longint EMF_HI = (longint'(1) << (EMF_W-1)) - 1;
  localparam longint EMF_LO = -(longint'(1) << (EMF_W-1));

  logic                    clk;
  logic                    rst_n;
  logic                    val_ready;
  logic [16*NUM_CH-1:0]    cur_cmd;
  logic [16*NUM_CH-1:0]    cur_fb;
  logic                    cfg_wr;
  logic [1:0]              cfg_addr;
  logic [15:0]             cfg_data;
  logic                    busy;
  logic                    emf_ready;
  logic [EMF_W*NUM_CH-1:0] emf_out;
  logic [NUM_CH-1:0]       emf_ovf;
  logic                    trig_miss;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  motor_emf_multi #(
    .NUM_CH(NUM_CH), .EMF_W(EMF_W), .GAIN(GAIN), .RES_RST(RES_RST), .FILT_SHIFT(FILT_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .val_ready(val_ready), .cur_cmd(cur_cmd), .cur_fb(cur_fb),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy),
    .emf_ready(emf_ready), .emf_out(emf_out), .emf_ovf(emf_ovf), .trig_miss(trig_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clampv(input longint v, output bit ovf);
    ovf = (v > EMF_HI) || (v < EMF_LO);
    if (v > EMF_HI) return EMF_HI;
    if (v < EMF_LO) return EMF_LO;
    return v;
  endfunction

  function automatic longint sgn16(input logic [15:0] x);
    return longint'(x) - 32768;
  endfunction

  function automatic logic [63:0] cur4(input int a, input int b, input int c, input int d);
    logic [15:0] w0, w1, w2, w3;
    w0 = 16'(a + 32768); w1 = 16'(b + 32768); w2 = 16'(c + 32768); w3 = 16'(d + 32768);
    return {w3, w2, w1, w0};
  endfunction

  function automatic longint ch_val(input int i);
    logic signed [EMF_W-1:0] v;
    v = emf_out[i*EMF_W +: EMF_W];
    return longint'(v);
  endfunction

  // ---------------- reference model ----------------
  longint res_m    [NUM_CH];
  longint exp_out  [NUM_CH];
  bit     exp_ovf  [NUM_CH];
  longint y_m      [NUM_CH];
  longint pend_d   [NUM_CH];
  bit     pend_ovf [NUM_CH];
  bit     exp_busy, exp_ready, exp_miss, active, vr_prev, m_trig, dummy_ovf;
  int     age;
  longint m_cs, m_fs, m_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        res_m[i] = RES_RST; exp_out[i] = 0; exp_ovf[i] = 0; y_m[i] = 0;
        pend_d[i] = 0; pend_ovf[i] = 0;
      end
      exp_busy = 0; exp_ready = 0; exp_miss = 0; active = 0; age = 0; vr_prev = 0;
    end else begin
      m_trig    = val_ready && !vr_prev;
      exp_ready = 0;
      exp_miss  = 0;
      if (active) begin
        exp_miss = m_trig;
        age++;
        if (age == 1) begin
          for (int i = 0; i < NUM_CH; i++) begin
            m_cs = sgn16(cur_cmd[16*i +: 16]);
            m_fs = sgn16(cur_fb[16*i +: 16]);
            m_d  = floor_div((m_cs - m_fs) * GAIN, 256) - floor_div(m_fs * res_m[i], 256);
            pend_d[i] = clampv(m_d, pend_ovf[i]);
          end
        end
        if (age == LAT - 1) begin
          for (int i = 0; i < NUM_CH; i++) begin
`ifdef MOTOR_EMF_FILTER_EN
            y_m[i] = clampv(y_m[i] + floor_div(pend_d[i] - y_m[i], longint'(1) << FILT_SHIFT),
                            dummy_ovf);
            exp_out[i] = y_m[i];
`else
            exp_out[i] = pend_d[i];
`endif
            exp_ovf[i] = pend_ovf[i];
          end
          exp_ready = 1;
          exp_busy  = 0;
        end
        if (age == LAT) active = 0;
      end else if (m_trig) begin
        active = 1; age = 0; exp_busy = 1;
      end
      if (cfg_wr && (int'(cfg_addr) < NUM_CH)) res_m[cfg_addr] = longint'(cfg_data);
      vr_prev = val_ready;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", longint'(busy), longint'(exp_busy));
      chk("emf_ready", longint'(emf_ready), longint'(exp_ready));
      chk("trig_miss", longint'(trig_miss), longint'(exp_miss));
      for (int i = 0; i < NUM_CH; i++) begin
        chk($sformatf("emf_out[%0d]", i), ch_val(i), exp_out[i]);
        chk($sformatf("emf_ovf[%0d]", i), longint'(emf_ovf[i]), longint'(exp_ovf[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_conv(input logic [63:0] cmd, input logic [63:0] fb, input int wr_cyc,
                          input logic [1:0] wr_addr, input logic [15:0] wr_data,
                          input int retrig, input bit hold, output int lat, output int misses);
    bit seen;
    seen = 0; lat = -1; misses = 0;
    @(posedge clk); #1;
    cur_cmd = cmd; cur_fb = fb;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      val_ready = (c < 2) || hold || (c == retrig);
      cfg_wr    = (c == wr_cyc);
      cfg_addr  = wr_addr;
      cfg_data  = wr_data;
      @(negedge clk);
      if (trig_miss) misses++;
      if (emf_ready) begin seen = 1; lat = c; end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      val_ready = hold; cfg_wr = 1'b0;
      @(negedge clk);
      if (trig_miss) misses++;
    end
    @(posedge clk); #1;
    val_ready = 1'b0;
  endtask

  int lat, misses, nready;

  initial begin
    rst_n = 1'b0; val_ready = 1'b0; cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_data = 16'd0;
    cur_cmd = {NUM_CH{16'h8000}}; cur_fb = {NUM_CH{16'h8000}};
    #2 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", longint'(busy), 0);
    chk("reset emf_out", longint'(emf_out != '0), 0);
    chk("reset emf_ovf", longint'(emf_ovf), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // basic gain path and latency
    run_conv(cur4(1000, 300, -300, 0), cur4(0, 100, -50, 0), -1, 2'd0, 16'd0, -1, 0, lat, misses);
    chk("latency t1", lat, 14);
`ifndef MOTOR_EMF_FILTER_EN
    chk("t1 ch0", ch_val(0), 47750);
    chk("t1 ovf0", longint'(emf_ovf[0]), 0);
`endif
    // resistive term only, floor behaviour
    run_conv(cur4(500, -1, 0, 1234), cur4(500, -1, 0, -77), -1, 2'd0, 16'd0, -1, 0, lat, misses);
    chk("latency t2", lat, 14);
`ifndef MOTOR_EMF_FILTER_EN
    chk("t2 ch0", ch_val(0), -3964);
    chk("t2 ch1", ch_val(1), 8);
    chk("t2 ch2", ch_val(2), 0);
`endif
    // saturation both ways
    run_conv(cur4(7, 20000, -20000, 0), cur4(3, -20000, 20000, 0), -1, 2'd0, 16'd0, -1, 0,
             lat, misses);
    chk("latency t3", lat, 14);
`ifndef MOTOR_EMF_FILTER_EN
    chk("t3 ch1", ch_val(1), 65535);
    chk("t3 ch2", ch_val(2), -65536);
    chk("t3 ch0", ch_val(0), 168);
    chk("t3 ovf", longint'(emf_ovf), 4'b0110);
`endif
    // RES write mid-conversion hits only the next conversion
    run_conv(cur4(0, 0, 500, 0), cur4(0, 0, 500, 0), 5, 2'd2, 16'd0, -1, 0, lat, misses);
`ifndef MOTOR_EMF_FILTER_EN
    chk("t4 ch2 old res", ch_val(2), -3964);
`endif
    run_conv(cur4(0, 0, 500, 0), cur4(0, 0, 500, 0), -1, 2'd0, 16'd0, -1, 0, lat, misses);
`ifndef MOTOR_EMF_FILTER_EN
    chk("t4 ch2 new res", ch_val(2), 0);
`endif
    // write in the capture cycle: snapshot keeps old value
    run_conv(cur4(0, 500, 0, 0), cur4(0, 500, 0, 0), 1, 2'd1, 16'd1000, -1, 0, lat, misses);
`ifndef MOTOR_EMF_FILTER_EN
    chk("capt wr ch1", ch_val(1), -3964);
`endif
    run_conv(cur4(0, 500, 0, 0), cur4(0, 500, 0, 0), -1, 2'd0, 16'd0, -1, 0, lat, misses);
`ifndef MOTOR_EMF_FILTER_EN
    chk("capt wr next ch1", ch_val(1), -1953);
`endif
    // retriggers while busy and in the DONE cycle, held level
    run_conv(cur4(100, 200, 300, 400), cur4(5, 6, 7, 8), -1, 2'd0, 16'd0, 5, 0, lat, misses);
    chk("retrig5 misses", misses, 1);
    chk("retrig5 latency", lat, 14);
    run_conv(cur4(-100, 20, 30, 40), cur4(5, -6, 7, -8), -1, 2'd0, 16'd0, 14, 0, lat, misses);
    chk("retrig done misses", misses, 1);
    run_conv(cur4(1, 2, 3, 4), cur4(4, 3, 2, 1), -1, 2'd0, 16'd0, -1, 1, lat, misses);
    chk("held misses", misses, 0);

    // reset during conversion
    @(posedge clk); #1;
    cur_cmd = cur4(1000, 0, 0, 0); cur_fb = cur4(0, 0, 0, 0); val_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      val_ready = (c < 2);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", longint'(busy), 0);
    chk("abort emf_out", longint'(emf_out != '0), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    nready = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (emf_ready) nready++;
    end
    chk("abort no ready", nready, 0);

    // step response from zero state
    run_conv(cur4(1000, 0, 0, 0), cur4(0, 0, 0, 0), -1, 2'd0, 16'd0, -1, 0, lat, misses);
`ifdef MOTOR_EMF_FILTER_EN
    chk("filter step1", ch_val(0), 5968);
`else
    chk("step1", ch_val(0), 47750);
`endif
    run_conv(cur4(1000, 0, 0, 0), cur4(0, 0, 0, 0), -1, 2'd0, 16'd0, -1, 0, lat, misses);
`ifdef MOTOR_EMF_FILTER_EN
    chk("filter step2", ch_val(0), 11190);
`else
    chk("step2", ch_val(0), 47750);
`endif

    // randomized conversions, RES writes and retriggers
    for (int n = 0; n < 30; n++) begin
      logic [63:0] rc, rf;
      int wr, rt;
      bit hd;
      for (int i = 0; i < NUM_CH; i++) begin
        rc[16*i +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535))
                                                     : 16'(32768 + $urandom_range(0, 4000) - 2000);
        rf[16*i +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535))
                                                     : 16'(32768 + $urandom_range(0, 4000) - 2000);
      end
      wr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 16)) : -1;
      rt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 15)) : -1;
      hd = ($urandom_range(0, 4) == 0);
      run_conv(rc, rf, wr, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 4095)), rt, hd,
               lat, misses);
      chk("random latency", lat, 14);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
